fsm_moore: RTL and testbench
============================

Name: fsm_moore

Overview:
- Two-state Moore FSM that drives one LED from a slide-switch level.
- An optional input conditioner sits in front of the FSM. It provides a synchronizer chain and a debounce filter.
- The LED output depends only on the state register and never combinationally on `sw`.
- Used as a board-level demo block between a raw switch pin and an LED pin.

Parameters:
- SYNC_STAGES, 0: number of flip-flops in the `sw` synchronizer chain. Legal values are 0, 2 and 3; 0 means bypass.
- DEBOUNCE_CYCLES, 0: number of consecutive cycles the conditioned `sw` must be stable before the FSM sees the change. 0 means bypass. Legal range is 0 to 2^20-1.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset. Assertion is async; release should be synchronous to `clk` upstream.
- sw  input  1  raw switch level; 1 = on.
- led  output  1  LED drive; 1 = lit. Registered; equals "state is S_ON".

Behaviour:
- States: S_OFF (led=0), S_ON (led=1). Use a 1-bit encoding.
- Reset (reset=0):
  - state goes to S_OFF immediately, without waiting for `clk`, so led=0 asynchronously.
  - All synchronizer flops clear to 0, the debounce counter clears to 0, and the filtered value clears to 0.
- Transitions, evaluated on each rising `clk` edge with reset=1, where `sw_c` is the conditioned switch:
  - S_OFF: sw_c=1 -> S_ON; otherwise stay.
  - S_ON: sw_c=0 -> S_OFF; otherwise stay.
- led is decoded from the state register only. No glitches while the state is stable.
- Latency with SYNC_STAGES=0 and DEBOUNCE_CYCLES=0: a change on `sw` sampled at edge N appears on `led` right after edge N (1 cycle).
- General latency: SYNC_STAGES + (DEBOUNCE_CYCLES>0 ? DEBOUNCE_CYCLES+1 : 0) + 1 cycles.
- Debounce:
  - The counter increments while sw_sync differs from the filtered value.
  - It resets to 0 whenever sw_sync equals the filtered value.
  - When the counter reaches DEBOUNCE_CYCLES, the filtered value takes sw_sync and the counter clears.
  - A pulse shorter than DEBOUNCE_CYCLES never reaches the FSM.
- A one-cycle `sw` pulse with conditioning bypassed produces a one-cycle `led` pulse, delayed by one cycle.
- Reset mid-operation: S_ON returns to S_OFF immediately and a partial debounce count is discarded. After release, the FSM re-evaluates `sw` from scratch.
- Illegal state cannot occur with the 1-bit encoding. If the encoding is widened, the default branch goes to S_OFF.
- `sw` toggling at every edge with bypass: `led` follows with a 1-cycle lag and no missed toggles.

Decomposition:
- Package fsm_moore_pkg:
  - state type with S_OFF=1'b0 and S_ON=1'b1.
  - LED_OFF/LED_ON constants.
- Sub-module sw_conditioner:
  - holds the synchronizer and the debounce counter, parameterized by SYNC_STAGES and DEBOUNCE_CYCLES.
  - ports clk, reset, sw_in, sw_out.
  - pure wire-through when both parameters are 0.
- The top contains the state register, next-state logic and output decode.

Test Plan (defaults unless stated):
1. Reset: hold reset=0 with sw=1 for 3 cycles -> led=0 throughout. Release reset -> led=1 after the next edge.
2. Single on/off, sw high for one cycle (10 ns, clk period 10 ns):
   - Stimulus: sw=1 at t=15 ns, sw=0 at t=25 ns.
   - Response: led=1 from the edge at 20 ns until the edge at 30 ns, then led=0.
3. Async reset mid-ON:
   - With led=1, pull reset low between clock edges -> led=0 within the same cycle (before the next edge).
   - Debounce count cleared.
4. Toggle stress: sw toggles every cycle for 16 cycles -> led equals sw delayed by exactly 1 cycle, with no mismatch.
5. Conditioned path, SYNC_STAGES=2 and DEBOUNCE_CYCLES=4:
   - 3-cycle sw pulse -> led stays 0.
   - Sustained sw=1 -> led=1 exactly 2+5+1=8 cycles after sw rises.
6. Hold stability: sw held at 1 for 100 cycles -> led stays 1 and state never leaves S_ON.

Source files
------------

// File: rtl/fsm_moore_pkg.sv
// Shared types and constants for the switch-to-LED Moore FSM.
package fsm_moore_pkg;

  typedef enum logic {
    S_OFF = 1'b0,
    S_ON  = 1'b1
  } state_t;

  localparam logic LED_OFF = 1'b0;
  localparam logic LED_ON  = 1'b1;

  // Counter width able to hold 0..cycles; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    if (cycles < 1) begin
      return 1;
    end
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sw_conditioner.sv
// Optional synchronizer chain followed by an optional debounce filter.
// With both stages bypassed the block is a plain wire from sw_in to sw_out.
module sw_conditioner
  import fsm_moore_pkg::*;
#(
  parameter int SYNC_STAGES     = 0,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_in,
  output logic sw_out
);

  logic sw_sync;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sw_sync = sw_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync_reg <= '0;
        end else begin
          sync_reg[0] <= sw_in;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_reg[i] <= sync_reg[i-1];
          end
        end
      end

      assign sw_sync = sync_reg[SYNC_STAGES-1];
    end
  endgenerate

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_nodeb
      assign sw_out = sw_sync;
    end else begin : g_deb
      localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
      localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

      logic [CNT_W-1:0] cnt_reg;
      logic             filt_reg;

      // The new level is accepted on the sample after the count hits CNT_MAX,
      // so it must persist for DEBOUNCE_CYCLES+1 consecutive samples.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_reg  <= '0;
          filt_reg <= 1'b0;
        end else if (sw_sync != filt_reg) begin
          if (cnt_reg == CNT_MAX) begin
            filt_reg <= sw_sync;
            cnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end else begin
          cnt_reg <= '0;
        end
      end

      assign sw_out = filt_reg;
    end
  endgenerate

  generate
    if (SYNC_STAGES == 0 && DEBOUNCE_CYCLES == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset;
    end
  endgenerate

endmodule

// File: rtl/fsm_moore.sv
// Two-state Moore FSM lighting an LED while the conditioned switch is on.
// The LED is a register output and never depends combinationally on sw.
module fsm_moore
  import fsm_moore_pkg::*;
#(
  parameter int SYNC_STAGES     = 0,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic led
);

  logic   sw_c;
  state_t state_reg;
  logic   led_reg;

  sw_conditioner #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_cond (
    .clk   (clk),
    .reset (reset),
    .sw_in (sw),
    .sw_out(sw_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_OFF;
      led_reg   <= LED_OFF;
    end else begin
      case (state_reg)
        S_OFF: begin
          if (sw_c) begin
            state_reg <= S_ON;
            led_reg   <= LED_ON;
          end
        end
        S_ON: begin
          if (!sw_c) begin
            state_reg <= S_OFF;
            led_reg   <= LED_OFF;
          end
        end
        // Only reachable if the state encoding is ever widened.
        default: begin
          state_reg <= S_OFF;
          led_reg   <= LED_OFF;
        end
      endcase
    end
  end

  assign led = led_reg;

endmodule

// File: tb/tb_fsm_moore.sv
// Directed and randomized checks of fsm_moore, bypassed and conditioned.
module tb_fsm_moore;

  localparam int C_SYNC = 2;
  localparam int C_DEB  = 4;

  logic clk   = 1'b1;
  logic reset = 1'b0;
  logic sw_b  = 1'b0;
  logic sw_c  = 1'b0;
  logic led_b;
  logic led_c;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  fsm_moore dut_b (
    .clk  (clk),
    .reset(reset),
    .sw   (sw_b),
    .led  (led_b)
  );

  fsm_moore #(
    .SYNC_STAGES    (C_SYNC),
    .DEBOUNCE_CYCLES(C_DEB)
  ) dut_c (
    .clk  (clk),
    .reset(reset),
    .sw   (sw_c),
    .led  (led_c)
  );

  // Behavioural model: bypass LED is the switch one edge late; the conditioned
  // LED follows a level only once it has been seen, after the synchronizer
  // delay, on more than C_DEB consecutive samples.
  bit m_led_b;
  bit m_led_c;
  bit m_filt;
  int m_run;
  bit m_hist[$];

  function automatic void model_clear();
    m_led_b = 1'b0;
    m_led_c = 1'b0;
    m_filt  = 1'b0;
    m_run   = 0;
    m_hist.delete();
  endfunction

  function automatic void model_edge();
    bit sync;
    if (!reset) begin
      model_clear();
      return;
    end
    m_led_b = sw_b;
    sync = (m_hist.size() >= C_SYNC) ? m_hist[m_hist.size() - C_SYNC] : 1'b0;
    m_led_c = m_filt;
    if (sync != m_filt) begin
      m_run++;
      if (m_run == C_DEB + 1) begin
        m_filt = sync;
        m_run  = 0;
      end
    end else begin
      m_run = 0;
    end
    m_hist.push_back(sw_c);
    if (m_hist.size() > C_SYNC) void'(m_hist.pop_front());
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked 1 ns after the rising edge.
  task automatic cycle(input logic r, input logic b, input logic c, input string tag);
    @(negedge clk);
    reset = r;
    sw_b  = b;
    sw_c  = c;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    $display("cyc %0d %s rst=%b sw_b=%b led_b=%b sw_c=%b led_c=%b",
             cyc, tag, reset, sw_b, led_b, sw_c, led_c);
    chk({tag, "_led_b"}, 32'(led_b), 32'(m_led_b));
    chk({tag, "_led_c"}, 32'(led_c), 32'(m_led_c));
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_clear();
    $display("async reset %s t=%0t led_b=%b led_c=%b", tag, $time, led_b, led_c);
    chk({tag, "_async_b"}, 32'(led_b), 32'(1'b0));
    chk({tag, "_async_c"}, 32'(led_c), 32'(1'b0));
  endtask

  initial begin
    int lat;
    int run_left;
    logic rv;
    logic bv;
    logic cv;

    model_clear();

    // Reset held with sw=1, then released.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b1, "t1_hold");
      chk("t1_hold_off", 32'(led_b), 32'(1'b0));
    end
    cycle(1'b1, 1'b1, 1'b1, "t1_rel");
    chk("t1_rel_on", 32'(led_b), 32'(1'b1));
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b0, "settle");

    // One-cycle pulse through the bypass path.
    cycle(1'b1, 1'b1, 1'b0, "t2_pulse");
    chk("t2_pulse_hi", 32'(led_b), 32'(1'b1));
    cycle(1'b1, 1'b0, 1'b0, "t2_pulse_end");
    chk("t2_pulse_lo", 32'(led_b), 32'(1'b0));

    // Toggle every cycle.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, logic'(i % 2 == 0), 1'b0, "t4_toggle");
    end
    cycle(1'b1, 1'b0, 1'b0, "t4_tail");

    // A pulse shorter than the debounce window is filtered.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, "t5_short");
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 1'b0, "t5_quiet");
      chk("t5_short_filtered", 32'(led_c), 32'(1'b0));
    end

    // Sustained rise: LED follows after sync + debounce + state latency.
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b1, 1'b0, 1'b1, "t5_rise");
      if (led_c === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("t5_latency", 32'(lat), 32'(8));

    // Long hold keeps both LEDs lit.
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 1'b1, 1'b1, "t6_hold");
      chk("t6_hold_b", 32'(led_b), 32'(1'b1));
      chk("t6_hold_c", 32'(led_c), 32'(1'b1));
    end

    // Reset between edges while lit.
    async_reset("t3_on");
    cycle(1'b0, 1'b0, 1'b0, "t3_in_reset");
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, "t3_settle");

    // Partial debounce count must be discarded by reset.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1, "t3_partial");
    async_reset("t3_partial");
    cycle(1'b0, 1'b0, 1'b1, "t3_in_reset2");
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b1, 1'b0, 1'b1, "t3_recount");
      if (led_c === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("t3_full_latency", 32'(lat), 32'(8));

    // Randomized traffic with occasional resets.
    run_left = 0;
    cv = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (run_left == 0) begin
        cv = logic'($urandom_range(0, 1));
        run_left = $urandom_range(1, 8);
      end
      run_left--;
      bv = logic'($urandom_range(0, 1));
      rv = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      cycle(rv, bv, cv, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
